// File: rtl/keccak_perm_arbiter.sv
// keccak_perm_arbiter
//
// Shares one Keccak-f[1600] permutation core between NUM_REQ requesters.
// A four-state FSM (IDLE, LAUNCH, BUSY, RESP) picks a winner round-robin,
// captures the winner's state, starts the core, waits for the core to
// finish, and returns the permuted state with a one-cycle done pulse.
//
// Parameters:
//   NUM_REQ      number of requesters (2..4)
//   TIMEOUT_CYC  watchdog limit in BUSY cycles (only with KPA_TIMEOUT_EN)
//
// Configuration macro:
//   KPA_TIMEOUT_EN  when defined, a watchdog forces BUSY->RESP after
//                   TIMEOUT_CYC cycles without perm_done, flags err and
//                   returns the unpermuted state. When undefined, BUSY
//                   waits indefinitely and err is constant 0.
//
// Ports:
//   clk             clock, rising edge
//   reset_n         asynchronous active-low reset
//   req             per-requester request level
//   req_state       flattened input states, requester i at [1600*i +: 1600]
//   gnt             one-hot grant, LAUNCH through RESP
//   done            one-cycle completion pulse to the granted requester
//   res_state       permuted state, held until the next RESP
//   err             timeout flag, valid with done
//   busy            high in any state other than IDLE
//   perm_start      one-cycle start pulse to the core
//   perm_state_in   registered state presented to the core
//   perm_state_out  core result, valid with perm_done
//   perm_done       core one-cycle completion pulse

module keccak_perm_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [1600*NUM_REQ-1:0]   req_state,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [1599:0]             res_state,
    output logic                      err,
    output logic                      busy,
    output logic                      perm_start,
    output logic [1599:0]             perm_state_in,
    input  logic [1599:0]             perm_state_out,
    input  logic                      perm_done
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Reject configurations the arbiter was never meant to handle.
    if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
        $error("keccak_perm_arbiter: NUM_REQ must be in 2..4");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("keccak_perm_arbiter: TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   win_q;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   cand;
    logic               found;
    logic               any_req;
    logic [NUM_REQ-1:0] win_onehot;
    logic               finish_busy;

`ifdef KPA_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0]   cnt;
    logic               timeout_hit;
    logic               err_q;

    // The BUSY cycle in which the counter would step to TIMEOUT_CYC is the
    // last one the watchdog allows.
    assign timeout_hit = (state == BUSY) && (cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign finish_busy = (state == BUSY) && (perm_done || timeout_hit);
`else
    assign finish_busy = (state == BUSY) && perm_done;
`endif

    assign any_req = |req;

    // Round-robin search: walk upward from the pointer, wrapping modulo
    // NUM_REQ, and take the first requester whose req bit is set.
    always_comb begin
        found   = 1'b0;
        win_idx = ptr;
        cand    = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = PTR_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Next-state logic; perm_done only matters while BUSY, so strays in any
    // other state fall through the defaults.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = BUSY;
            BUSY:    if (finish_busy) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Winner capture, pointer advance and result capture. The winner's
    // state is sampled only in the IDLE cycle it wins, so requesters may
    // change req_state freely afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr           <= '0;
            win_q         <= '0;
            perm_state_in <= '0;
            res_state     <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                win_q         <= win_idx;
                perm_state_in <= req_state[1600*int'(win_idx) +: 1600];
            end
            if (state == BUSY && perm_done) begin
                res_state <= perm_state_out;
            end
`ifdef KPA_TIMEOUT_EN
            else if (timeout_hit) begin
                res_state <= perm_state_in;
            end
`endif
            if (state == RESP) begin
                ptr <= PTR_W'((int'(win_q) + 1) % NUM_REQ);
            end
        end
    end

`ifdef KPA_TIMEOUT_EN
    // Watchdog: cleared as BUSY is entered, counts every BUSY cycle. The
    // error flag records whether BUSY ended by timeout; a perm_done in the
    // same cycle as the timeout wins and leaves the flag clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == LAUNCH) begin
                cnt <= '0;
            end else if (state == BUSY) begin
                cnt <= cnt + 1'b1;
            end
            if (finish_busy) begin
                err_q <= !perm_done;
            end
        end
    end

    assign err = (state == RESP) && err_q;
`else
    assign err = 1'b0;
`endif

    assign win_onehot = NUM_REQ'(1) << win_q;
    assign gnt        = (state != IDLE) ? win_onehot : '0;
    assign done       = (state == RESP) ? win_onehot : '0;
    assign busy       = (state != IDLE);
    assign perm_start = (state == LAUNCH);

endmodule

// File: tb/tb_keccak_perm_arbiter.sv
// tb_keccak_perm_arbiter
//
// Directed self-checking bench for keccak_perm_arbiter with NUM_REQ=2.
// A behavioural core answers perm_start with perm_done K cycles later and
// returns a simple reversible scramble of the captured state, so the
// expected res_state is computed here from the state the bench drove.
// Define KPA_TIMEOUT_EN to also exercise the watchdog.

module tb_keccak_perm_arbiter;

    localparam int NUM_REQ     = 2;
    localparam int TIMEOUT_CYC = 64;
    localparam int K           = 24;

    logic                    clk;
    logic                    reset_n;
    logic [NUM_REQ-1:0]      req;
    logic [1600*NUM_REQ-1:0] req_state;
    logic [NUM_REQ-1:0]      gnt;
    logic [NUM_REQ-1:0]      done;
    logic [1599:0]           res_state;
    logic                    err;
    logic                    busy;
    logic                    perm_start;
    logic [1599:0]           perm_state_in;
    logic [1599:0]           perm_state_out;
    logic                    perm_done;

    logic                    core_en;
    logic                    stray_done;
    logic                    core_busy;
    int                      core_cnt;
    logic [1599:0]           core_in;

    int                      cyc;
    int                      n_checks;
    int                      n_fail;

    keccak_perm_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .req_state      (req_state),
        .gnt            (gnt),
        .done           (done),
        .res_state      (res_state),
        .err            (err),
        .busy           (busy),
        .perm_start     (perm_start),
        .perm_state_in  (perm_state_in),
        .perm_state_out (perm_state_out),
        .perm_done      (perm_done)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to measure latencies; stable at every negedge.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for a distinct per-lane state.
    function automatic logic [1599:0] mkState(input logic [31:0] seed);
        logic [1599:0] s;
        for (int i = 0; i < 25; i++) begin
            s[64*i +: 64] = {seed, 32'(i)};
        end
        return s;
    endfunction

    // Stand-in for Keccak-f: xor with a constant, rotate left by one bit.
    function automatic logic [1599:0] permModel(input logic [1599:0] x);
        logic [1599:0] y;
        y = x ^ {25{64'h0123_4567_89AB_CDEF}};
        return {y[1598:0], y[1599]};
    endfunction

    // Behavioural core: latches perm_state_in on perm_start and raises
    // perm_done during the K-th cycle after the start cycle.
    initial begin
        core_busy = 1'b0;
        core_cnt  = 0;
        core_in   = '0;
    end
    always @(posedge clk) begin
        if (core_busy) begin
            if (core_cnt == K) core_busy <= 1'b0;
            else               core_cnt  <= core_cnt + 1;
        end else if (perm_start && core_en) begin
            core_busy <= 1'b1;
            core_cnt  <= 1;
            core_in   <= perm_state_in;
        end
    end
    assign perm_done      = (core_busy && core_cnt == K) || stray_done;
    assign perm_state_out = permModel(core_in);

    // Compares one observed value with its expected value; on mismatch
    // reports the first differing 64-bit lane.
    task automatic checkOutput(input string tag, input logic [1599:0] got,
                               input logic [1599:0] exp);
        int lane;
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            lane = 0;
            for (int i = 24; i >= 0; i--) begin
                if (got[64*i +: 64] !== exp[64*i +: 64]) lane = i;
            end
            $display("[TB] FAIL %s: lane %0d got %h expected %h", tag, lane,
                     got[64*lane +: 64], exp[64*lane +: 64]);
        end
    endtask

    // Drives a new request pattern at the next falling edge.
    task automatic applyStimulus(input logic [NUM_REQ-1:0] r,
                                 input logic [1599:0] s0,
                                 input logic [1599:0] s1);
        @(negedge clk);
        req       = r;
        req_state = {s1, s0};
    endtask

    // Waits (bounded) for a done pulse, sampling on falling edges.
    task automatic waitDone(input int budget, output int at_cyc, output logic ok);
        ok     = 1'b0;
        at_cyc = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done != '0) begin
                ok     = 1'b1;
                at_cyc = cyc;
                break;
            end
        end
    endtask

    // Directed sequence.
    initial begin
        logic [1599:0] sa;
        logic [1599:0] sb;
        logic          ok;
        int            t0;
        int            t1;
        int            t2;
        int            seen;

        n_checks   = 0;
        n_fail     = 0;
        reset_n    = 1'b0;
        req        = '0;
        req_state  = '0;
        core_en    = 1'b1;
        stray_done = 1'b0;
        sa         = mkState(32'hA5A5_0001);
        sb         = mkState(32'h5A5A_0002);

        repeat (2) @(negedge clk);
        checkOutput("rst_gnt", gnt, '0);
        checkOutput("rst_done", done, '0);
        checkOutput("rst_err", err, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_start", perm_start, 1'b0);
        checkOutput("rst_state_in", perm_state_in, '0);
        checkOutput("rst_res", res_state, '0);
        reset_n = 1'b1;

        @(negedge clk);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        checkOutput("idle_stray_busy", busy, 1'b0);
        checkOutput("idle_stray_done", done, '0);

        applyStimulus(2'b01, sa, sb);
        t0 = cyc;
        @(negedge clk);
        checkOutput("launch_start", perm_start, 1'b1);
        checkOutput("launch_gnt", gnt, 2'b01);
        checkOutput("launch_state_in", perm_state_in, sa);
        checkOutput("launch_done", done, '0);
        req        = '0;
        req_state  = {mkState(32'hDEAD_0008), mkState(32'hDEAD_0009)};
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        checkOutput("busy_start", perm_start, 1'b0);
        checkOutput("busy_busy", busy, 1'b1);
        checkOutput("busy_gnt", gnt, 2'b01);
        checkOutput("busy_done", done, '0);
        waitDone(60, t1, ok);
        checkOutput("single_seen", ok, 1'b1);
        checkOutput("single_latency", t1 - t0, 26);
        checkOutput("single_done", done, 2'b01);
        checkOutput("single_err", err, 1'b0);
        checkOutput("single_res", res_state, permModel(sa));
        @(negedge clk);
        checkOutput("single_done_drop", done, '0);
        checkOutput("single_idle", busy, 1'b0);
        checkOutput("single_res_held", res_state, permModel(sa));

        applyStimulus(2'b01, sb, sa);
        @(negedge clk);
        req = '0;
        repeat (3) @(negedge clk);
        checkOutput("midrst_pre_busy", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_gnt", gnt, '0);
        @(negedge clk);
        reset_n    = 1'b1;
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done != '0 || busy) seen++;
        end
        checkOutput("midrst_quiet", seen, 0);

        @(negedge clk);
        reset_n   = 1'b0;
        req       = 2'b11;
        req_state = {sb, sa};
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            waitDone(60, t1, ok);
            checkOutput("rr_seen", ok, 1'b1);
            checkOutput("rr_done", done, (k % 2 == 0) ? 2'b01 : 2'b10);
            checkOutput("rr_res", res_state, permModel((k % 2 == 0) ? sa : sb));
        end
        req = '0;

        applyStimulus(2'b10, sa, sb);
        waitDone(60, t1, ok);
        checkOutput("b2b_first_seen", ok, 1'b1);
        checkOutput("b2b_first_done", done, 2'b10);
        waitDone(60, t2, ok);
        req = '0;
        checkOutput("b2b_second_seen", ok, 1'b1);
        checkOutput("b2b_second_done", done, 2'b10);
        checkOutput("b2b_gap", t2 - t1, K + 3);
        checkOutput("b2b_res", res_state, permModel(sb));

`ifdef KPA_TIMEOUT_EN
        repeat (3) @(negedge clk);
        core_en = 1'b0;
        applyStimulus(2'b01, sb, sa);
        @(negedge clk);
        req = '0;
        waitDone(TIMEOUT_CYC + 20, t1, ok);
        checkOutput("tmo_seen", ok, 1'b1);
        checkOutput("tmo_done", done, 2'b01);
        checkOutput("tmo_err", err, 1'b1);
        checkOutput("tmo_res", res_state, sb);
        core_en = 1'b1;
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
